audio_fx_router: RTL

//  Sample-framed router between the ADC FIFO (i2s_rx) and the DAC FIFO (i2s_tx), replacing free-running glue.
//  - Pops one stereo word, drives it to all effect instances and waits a fixed effect latency.
//  - Selects one effect return, pushes it to the DAC FIFO.
//  - Crossfades click-free when the effect selection changes.

---
 rtl/audio_fx_router_pkg.sv | 22 ++
 rtl/audio_fx_router_if.sv | 27 ++
 rtl/audio_xfade_ch.sv | 29 ++
 rtl/audio_fx_router.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/audio_fx_router_pkg.sv
// Shared types, widths and L/R field helpers for the audio effect router.
`ifndef AUDIO_FX_ROUTER_PKG_SV
`define AUDIO_FX_ROUTER_PKG_SV

`define AFX_L(w) w[15:0]
`define AFX_R(w) w[31:16]

package audio_fx_router_pkg;
   localparam int CH_W   = 16;
   localparam int WORD_W = 32;
   localparam int SEL_W  = 3;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_CAP  = 3'd1,
      ST_WAIT = 3'd2,
      ST_MIX  = 3'd3,
      ST_PUSH = 3'd4
   } state_e;
endpackage

`endif

// File: rtl/audio_fx_router_if.sv
// FIFO, effect-bus and control signals between the router and its surroundings.
interface audio_fx_router_if
   import audio_fx_router_pkg::*;
#(
   parameter int NUM_FX = 8
) ();
   logic [SEL_W-1:0]         effect_sel;
   logic                     adcfifo_empty;
   logic                     adcfifo_read;
   logic [WORD_W-1:0]        adcfifo_readdata;
   logic [WORD_W-1:0]        fx_in;
   logic [NUM_FX*WORD_W-1:0] fx_ret;
   logic                     dacfifo_full;
   logic                     dacfifo_write;
   logic [WORD_W-1:0]        dacfifo_writedata;
   logic                     xfade_busy;

   modport master (
      input  effect_sel, adcfifo_empty, adcfifo_readdata, fx_ret, dacfifo_full,
      output adcfifo_read, fx_in, dacfifo_write, dacfifo_writedata, xfade_busy
   );

   modport slave (
      output effect_sel, adcfifo_empty, adcfifo_readdata, fx_ret, dacfifo_full,
      input  adcfifo_read, fx_in, dacfifo_write, dacfifo_writedata, xfade_busy
   );
endinterface

// File: rtl/audio_xfade_ch.sv
// One-channel convex blend: y = (old*(N-k) + new*k) >>> XFADE_LOG2, floor rounding.
module audio_xfade_ch
   import audio_fx_router_pkg::*;
#(
   parameter int XFADE_LOG2 = 8
) (
   input  logic signed [CH_W-1:0]       old_i,
   input  logic signed [CH_W-1:0]       new_i,
   input  logic        [XFADE_LOG2-1:0] k_i,
   output logic signed [CH_W-1:0]       y_o
);
   // Weights carry two spare bits so N itself is representable as a positive signed value.
   localparam int PW = CH_W + XFADE_LOG2 + 2;
   localparam logic signed [PW-1:0] N_X = PW'(1) << XFADE_LOG2;

   logic signed [PW-1:0] o_x, n_x, wk_x, wn_x, p_old, p_new;
   logic signed [PW:0]   sum;

   always_comb begin
      o_x   = PW'(old_i);
      n_x   = PW'(new_i);
      wk_x  = PW'({1'b0, k_i});
      wn_x  = N_X - wk_x;
      p_old = o_x * wn_x;
      p_new = n_x * wk_x;
      sum   = (PW+1)'(p_old) + (PW+1)'(p_new);
      y_o   = CH_W'(sum >>> XFADE_LOG2);
   end
endmodule

// File: rtl/audio_fx_router.sv
// Sample-framed ADC->effects->DAC router with click-free crossfade on slot change.
module audio_fx_router
   import audio_fx_router_pkg::*;
#(
   parameter int NUM_FX     = 8,
   parameter int FX_LATENCY = 4,
   parameter int XFADE_LOG2 = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   audio_fx_router_if.master  bus
);
   localparam int CNT_W = $clog2(FX_LATENCY + 1);
   localparam logic [XFADE_LOG2-1:0] K_LAST = '1;

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [WORD_W-1:0]       fx_in_q, fx_in_d;
   logic [WORD_W-1:0]       old_ret_q, old_ret_d, new_ret_q, new_ret_d;
   logic [WORD_W-1:0]       out_q, out_d;
   logic [SEL_W-1:0]        cur_sel_q, cur_sel_d, old_sel_q, old_sel_d;
   logic [XFADE_LOG2-1:0]   fade_k_q, fade_k_d;
   logic                    busy_q, busy_d;
   logic                    rd, wr;
   logic [SEL_W-1:0]        sel_s;
   logic [WORD_W-1:0]       ret_old, ret_new;
   logic [CH_W-1:0]         y_l, y_r;

   assign sel_s   = (int'(bus.effect_sel) >= NUM_FX) ? '0 : bus.effect_sel;
   assign ret_old = bus.fx_ret[WORD_W*int'(old_sel_q) +: WORD_W];
   assign ret_new = bus.fx_ret[WORD_W*int'(cur_sel_q) +: WORD_W];

   audio_xfade_ch #(.XFADE_LOG2(XFADE_LOG2)) u_xf_l (
      .old_i (`AFX_L(old_ret_q)),
      .new_i (`AFX_L(new_ret_q)),
      .k_i   (fade_k_q),
      .y_o   (y_l)
   );

   audio_xfade_ch #(.XFADE_LOG2(XFADE_LOG2)) u_xf_r (
      .old_i (`AFX_R(old_ret_q)),
      .new_i (`AFX_R(new_ret_q)),
      .k_i   (fade_k_q),
      .y_o   (y_r)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      fx_in_d   = fx_in_q;
      old_ret_d = old_ret_q;
      new_ret_d = new_ret_q;
      out_d     = out_q;
      cur_sel_d = cur_sel_q;
      old_sel_d = old_sel_q;
      fade_k_d  = fade_k_q;
      busy_d    = busy_q;
      rd        = 1'b0;
      wr        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // Selection is only sampled between samples; changes mid-fade wait here.
            if (!busy_q && (sel_s != cur_sel_q)) begin
               old_sel_d = cur_sel_q;
               cur_sel_d = sel_s;
               fade_k_d  = '0;
               busy_d    = 1'b1;
            end
            if (!bus.adcfifo_empty) begin
               rd      = 1'b1;
               state_d = ST_CAP;
            end
         end
         ST_CAP: begin
            fx_in_d = bus.adcfifo_readdata;
            cnt_d   = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(FX_LATENCY - 1)) begin
               old_ret_d = ret_old;
               new_ret_d = ret_new;
               state_d   = ST_MIX;
            end
         end
         ST_MIX: begin
            out_d   = busy_q ? {y_r, y_l} : new_ret_q;
            state_d = ST_PUSH;
         end
         ST_PUSH: begin
            if (!bus.dacfifo_full) begin
               wr      = 1'b1;
               state_d = ST_IDLE;
               if (busy_q) begin
                  fade_k_d = fade_k_q + XFADE_LOG2'(1);
                  if (fade_k_q == K_LAST) begin
                     busy_d    = 1'b0;
                     old_sel_d = cur_sel_q;
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         fx_in_q   <= '0;
         old_ret_q <= '0;
         new_ret_q <= '0;
         out_q     <= '0;
         cur_sel_q <= '0;
         old_sel_q <= '0;
         fade_k_q  <= '0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         fx_in_q   <= fx_in_d;
         old_ret_q <= old_ret_d;
         new_ret_q <= new_ret_d;
         out_q     <= out_d;
         cur_sel_q <= cur_sel_d;
         old_sel_q <= old_sel_d;
         fade_k_q  <= fade_k_d;
         busy_q    <= busy_d;
      end
   end

   // The pop strobe is gated by reset so it cannot fire while the FSM is held in IDLE.
   assign bus.adcfifo_read      = rd & reset_n;
   assign bus.dacfifo_write     = wr;
   assign bus.dacfifo_writedata = out_q;
   assign bus.fx_in             = fx_in_q;
   assign bus.xfade_busy        = busy_q;
endmodule
